// File: rtl/config_pkg.sv
// Shared opcode constants, opcode/state enums and header helpers for the UART packet engine.
package config_pkg;

  localparam logic [7:0] OPC_ECHO  = 8'hEC;
  localparam logic [7:0] OPC_ADD   = 8'hA0;
  localparam logic [7:0] OPC_MUL   = 8'hA1;
  localparam logic [7:0] OPC_DIV   = 8'hA2;
  localparam logic [15:0] HDR_BYTES = 16'd4;

  typedef enum logic [7:0] {
    OP_ECHO = OPC_ECHO,
    OP_ADD  = OPC_ADD,
    OP_MUL  = OPC_MUL,
    OP_DIV  = OPC_DIV
  } opcode_t;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RESERVED,
    ST_LEN_LSB,
    ST_LEN_MSB,
    ST_PAYLOAD,
    ST_RESULT
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OPC_ECHO) || (b == OPC_ADD) || (b == OPC_MUL) || (b == OPC_DIV);
  endfunction

  // Length field counts the header too; short lengths mean an empty payload.
  function automatic logic [15:0] payload_len(input logic [15:0] len);
    return (len < HDR_BYTES) ? 16'd0 : len - HDR_BYTES;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide output FIFO; the head byte is read straight from the storage registers.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      if (push_ok && !pop_ok)
        count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_packet_engine.sv
// Packet parser between UART RX and TX: echoes payloads or reduces DATA_W-bit operands
// with ADD/MUL/DIV, buffering response bytes in an output FIFO.
module uart_packet_engine
  import config_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       err_o,
  output logic       busy_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t            state_q, state_nxt;
  opcode_t           opcode_q, opcode_nxt;
  logic [15:0]       cnt_q, cnt_nxt;
  logic [7:0]        len_lsb_q, len_lsb_nxt;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_nxt;
  logic [IDX_W-1:0]  res_idx_q, res_idx_nxt;
  logic              first_q, first_nxt;
  logic [DATA_W-1:0] acc_q, acc_nxt;
  logic [DATA_W-1:0] opnd_q, opnd_nxt;
  logic [DATA_W-1:0] opnd_full;
  logic [DATA_W-1:0] op_result;
  logic              opnd_done;
  logic              err_q, err_evt;

  logic              fifo_push;
  logic [7:0]        fifo_din;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ovf;

  assign fifo_pop  = valid_o && ready_i;
  assign valid_o   = !fifo_empty;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_OPCODE);

  // Operand bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign opnd_full = (opnd_q >> 8) | (DATA_W'(data_i) << (DATA_W - 8));
  assign opnd_done = (byte_idx_q == IDX_W'(BYTES - 1));

  always_comb begin
    case (opcode_q)
      OP_ADD:  op_result = acc_q + opnd_full;
      OP_MUL:  op_result = acc_q * opnd_full;
      OP_DIV:  op_result = (opnd_full == '0) ? '1 : acc_q / opnd_full;
      default: op_result = acc_q;
    endcase
  end

  always_comb begin
    state_nxt    = state_q;
    opcode_nxt   = opcode_q;
    cnt_nxt      = cnt_q;
    len_lsb_nxt  = len_lsb_q;
    byte_idx_nxt = byte_idx_q;
    res_idx_nxt  = res_idx_q;
    first_nxt    = first_q;
    acc_nxt      = acc_q;
    opnd_nxt     = opnd_q;
    err_evt      = 1'b0;
    fifo_push    = 1'b0;
    fifo_din     = data_i;
    case (state_q)
      ST_OPCODE: begin
        if (valid_i) begin
          if (is_opcode(data_i)) begin
            opcode_nxt = opcode_t'(data_i);
            state_nxt  = ST_RESERVED;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      ST_RESERVED: if (valid_i) state_nxt = ST_LEN_LSB;
      ST_LEN_LSB: begin
        if (valid_i) begin
          len_lsb_nxt = data_i;
          state_nxt   = ST_LEN_MSB;
        end
      end
      ST_LEN_MSB: begin
        if (valid_i) begin
          cnt_nxt      = payload_len({data_i, len_lsb_q});
          byte_idx_nxt = '0;
          first_nxt    = 1'b1;
          state_nxt    = (payload_len({data_i, len_lsb_q}) == 16'd0) ? ST_OPCODE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (valid_i) begin
          cnt_nxt = cnt_q - 16'd1;
          if (opcode_q == OP_ECHO) begin
            fifo_push = 1'b1;
            if (cnt_q == 16'd1) state_nxt = ST_OPCODE;
          end else begin
            opnd_nxt = opnd_full;
            if (opnd_done) begin
              byte_idx_nxt = '0;
              first_nxt    = 1'b0;
              acc_nxt      = first_q ? opnd_full : op_result;
            end else begin
              byte_idx_nxt = byte_idx_q + IDX_W'(1);
            end
            if (cnt_q == 16'd1) begin
              if (opnd_done) begin
                res_idx_nxt = '0;
                state_nxt   = ST_RESULT;
              end else begin
                err_evt   = 1'b1;
                state_nxt = ST_OPCODE;
              end
            end
          end
        end
      end
      ST_RESULT: begin
        if (valid_i) err_evt = 1'b1;
        fifo_din = 8'(acc_q >> {res_idx_q, 3'b000});
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          if (res_idx_q == IDX_W'(BYTES - 1)) state_nxt = ST_OPCODE;
          else res_idx_nxt = res_idx_q + IDX_W'(1);
        end
      end
      default: state_nxt = ST_OPCODE;
    endcase
  end

  // Stage boundary: control and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OPCODE;
      opcode_q   <= OP_ECHO;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      res_idx_q  <= '0;
      first_q    <= 1'b0;
      acc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      opcode_q   <= opcode_nxt;
      cnt_q      <= cnt_nxt;
      byte_idx_q <= byte_idx_nxt;
      res_idx_q  <= res_idx_nxt;
      first_q    <= first_nxt;
      acc_q      <= acc_nxt;
      err_q      <= err_evt | fifo_ovf;
    end
  end

  always_ff @(posedge clk) begin
    len_lsb_q <= len_lsb_nxt;
    opnd_q    <= opnd_nxt;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .rd_data   (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

endmodule

// File: tb/tb_uart_packet_engine.sv
// Directed bench for uart_packet_engine (DATA_W=32, FIFO_DEPTH=4).
module tb_uart_packet_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  uart_packet_engine #(
    .DATA_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  // Inputs change 1 ns after posedge; outputs are observed on negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && ready_i) rx_q.push_back(data_o);
      if (err_o) err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      @(posedge clk);
      #1;
      data_i  = pkt[i];
      valid_i = 1'b1;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  function automatic logic [7:0] rx(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic [31:0] rx_word();
    return {rx(3), rx(2), rx(1), rx(0)};
  endfunction

  task automatic clear();
    rx_q.delete();
    err_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; data_i = 8'h00; valid_i = 1'b0; ready_i = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_data_o", 32'(data_o), 32'h0);
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_err_o", 32'(err_o), 32'h0);
    chk("rst_busy_o", 32'(busy_o), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Echo three bytes.
    clear();
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt();
    idle(8);
    chk("echo_cnt", 32'(rx_q.size()), 32'd3);
    chk("echo_b0", 32'(rx(0)), 32'h41);
    chk("echo_b1", 32'(rx(1)), 32'h42);
    chk("echo_b2", 32'(rx(2)), 32'h43);
    chk("echo_err", 32'(err_cnt), 32'd0);
    chk("echo_idle", 32'(busy_o), 32'h0);

    // ADD with wrap-around: 5 + 0xFFFFFFFF = 4.
    clear();
    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt();
    idle(8);
    chk("add_cnt", 32'(rx_q.size()), 32'd4);
    chk("add_val", rx_word(), 32'h0000_0004);
    chk("add_err", 32'(err_cnt), 32'd0);

    // Divide by zero saturates to all ones without an error.
    clear();
    pkt = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt();
    idle(8);
    chk("div0_cnt", 32'(rx_q.size()), 32'd4);
    chk("div0_val", rx_word(), 32'hFFFF_FFFF);
    chk("div0_err", 32'(err_cnt), 32'd0);

    // MUL 3 * 7 = 21.
    clear();
    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
    idle(8);
    chk("mul_val", rx_word(), 32'h0000_0015);

    // Chained DIV over three operands: 100 / 5 / 2 = 10.
    clear();
    pkt = '{8'hA2, 8'h00, 8'h10, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    idle(8);
    chk("div3_val", rx_word(), 32'h0000_000A);

    // Payload not a multiple of the operand size.
    clear();
    pkt = '{8'hA1, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02};
    send_pkt();
    idle(6);
    chk("badlen_err", 32'(err_cnt), 32'd1);
    chk("badlen_out", 32'(rx_q.size()), 32'd0);
    chk("badlen_busy", 32'(busy_o), 32'h0);
    clear();
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_pkt();
    idle(6);
    chk("badlen_echo_cnt", 32'(rx_q.size()), 32'd1);
    chk("badlen_echo_b0", 32'(rx(0)), 32'h5A);

    // Length below the header size: no payload, no response.
    clear();
    pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
    send_pkt();
    idle(4);
    chk("short_out", 32'(rx_q.size()), 32'd0);
    chk("short_busy", 32'(busy_o), 32'h0);
    chk("short_err", 32'(err_cnt), 32'd0);

    // Backpressure with overflow: six echo bytes into a four-deep FIFO.
    clear();
    ready_i = 1'b0;
    pkt = '{8'hEC, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt();
    idle(4);
    chk("ovf_err", 32'(err_cnt), 32'd2);
    chk("ovf_valid", 32'(valid_o), 32'h1);
    chk("ovf_hold", 32'(data_o), 32'h11);
    idle(3);
    chk("ovf_hold2", 32'(data_o), 32'h11);
    ready_i = 1'b1;
    idle(8);
    chk("ovf_cnt", 32'(rx_q.size()), 32'd4);
    chk("ovf_bytes", {rx(0), rx(1), rx(2), rx(3)}, 32'h1122_3344);
    chk("ovf_empty", 32'(valid_o), 32'h0);

    // Unknown opcode, then reset in the middle of an echo payload.
    clear();
    pkt = '{8'h55};
    send_pkt();
    idle(3);
    chk("unk_err", 32'(err_cnt), 32'd1);
    chk("unk_busy", 32'(busy_o), 32'h0);
    ready_i = 1'b0;
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02};
    send_pkt();
    @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'h1);
    chk("mid_valid", 32'(valid_o), 32'h1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(valid_o), 32'h0);
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    ready_i = 1'b1;
    clear();
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    send_pkt();
    idle(6);
    chk("post_rst_cnt", 32'(rx_q.size()), 32'd1);
    chk("post_rst_b0", 32'(rx(0)), 32'h77);
    chk("post_rst_err", 32'(err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
